stream_pkt_buf: RTL and testbench



---
 rtl/stream_pkt_buf_pkg.sv | 19 +
 rtl/stream_pkt_buf_if.sv | 31 +++
 rtl/stream_pkt_buf_ram.sv | 24 ++
 rtl/stream_pkt_buf.sv | 119 +++++++++++
 tb/tb_stream_pkt_buf.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_pkt_buf_pkg.sv
// Shared helpers for the stream packet buffer. Beats are packed in the order
// {id, dest, data, strb, keep, last, user}; strb and keep are data_w/8 bits wide.
package stream_pkg;

    typedef enum logic {
        MODE_CUT_THROUGH = 1'b0,
        MODE_STORE_FWD   = 1'b1
    } pkt_mode_e;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int pack_width(input int id_w, input int dest_w,
                                      input int data_w, input int user_w);
        return id_w + dest_w + data_w + 2 * (data_w / 8) + 1 + user_w;
    endfunction

endpackage

// File: rtl/stream_pkt_buf_if.sv
// AXI-Stream style channel carrying its own clock and active-low asynchronous reset.
// The master modport drives beats, the slave modport accepts them.
interface stream_channel #(
    parameter int ID_W   = 4,
    parameter int DEST_W = 4,
    parameter int DATA_W = 32,
    parameter int USER_W = 2
) (
    input logic clk,
    input logic rstn
);
    logic                  t_valid;
    logic                  t_ready;
    logic [ID_W-1:0]       t_id;
    logic [DEST_W-1:0]     t_dest;
    logic [DATA_W-1:0]     t_data;
    logic [DATA_W/8-1:0]   t_strb;
    logic [DATA_W/8-1:0]   t_keep;
    logic                  t_last;
    logic [USER_W-1:0]     t_user;

    modport master (
        input  clk, rstn, t_ready,
        output t_valid, t_id, t_dest, t_data, t_strb, t_keep, t_last, t_user
    );

    modport slave (
        input  clk, rstn, t_valid, t_id, t_dest, t_data, t_strb, t_keep, t_last, t_user,
        output t_ready
    );
endinterface

// File: rtl/stream_pkt_buf_ram.sv
// Beat storage for stream_pkt_buf: synchronous write port, asynchronous read port.
// Contents are intentionally left unreset; the pointers alone define what is valid.
module stream_pkt_buf_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [WIDTH-1:0]         o_rd_data
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/stream_pkt_buf.sv
// stream_pkt_buf: power-of-two beat buffer with cut-through or store-and-forward delivery.
// Define STREAM_PKT_BUF_STATUS_EN to expose the level and pkt_count status ports.
module stream_pkt_buf
    import stream_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int PACKET_MODE = 0
) (
    stream_channel.slave  master,
    stream_channel.master slave
`ifdef STREAM_PKT_BUF_STATUS_EN
    ,
    output logic [ptr_width(DEPTH)-1:0] level,
    output logic [ptr_width(DEPTH)-1:0] pkt_count
`endif
);
    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = ptr_width(DEPTH);
    localparam int IDW = $bits(master.t_id);
    localparam int DSW = $bits(master.t_dest);
    localparam int DW  = $bits(master.t_data);
    localparam int UW  = $bits(master.t_user);
    localparam int PKW = pack_width(IDW, DSW, DW, UW);
    localparam pkt_mode_e MODE = (PACKET_MODE != 0) ? MODE_STORE_FWD : MODE_CUT_THROUGH;

    if ($bits(slave.t_id) != IDW || $bits(slave.t_dest) != DSW ||
        $bits(slave.t_data) != DW || $bits(slave.t_user) != UW) begin : g_width_check
        $fatal(1, "stream_pkt_buf: master and slave channel widths differ");
    end

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $fatal(1, "stream_pkt_buf: DEPTH must be a power of two and at least 2");
    end

    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [PW-1:0]  r_pkt_cnt;
    logic           r_force_ct;
    logic           w_empty;
    logic           w_full;
    logic           w_wr_en;
    logic           w_rd_en;
    logic           w_wr_last;
    logic           w_rd_last;
    logic [PKW-1:0] w_wr_pack;
    logic [PKW-1:0] w_rd_pack;

    // The extra top pointer bit tells a full buffer apart from an empty one.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign master.t_ready = !w_full;
    assign slave.t_valid  = !w_empty &&
                            (MODE == MODE_CUT_THROUGH || r_pkt_cnt != '0 || r_force_ct);

    assign w_wr_en   = master.t_valid && !w_full;
    assign w_rd_en   = slave.t_valid && slave.t_ready;
    assign w_wr_last = w_wr_en && master.t_last;
    assign w_rd_last = w_rd_en && slave.t_last;

    assign w_wr_pack = {master.t_id, master.t_dest, master.t_data, master.t_strb,
                        master.t_keep, master.t_last, master.t_user};
    assign {slave.t_id, slave.t_dest, slave.t_data, slave.t_strb,
            slave.t_keep, slave.t_last, slave.t_user} = w_rd_pack;

    stream_pkt_buf_ram #(
        .DEPTH (DEPTH),
        .WIDTH (PKW)
    ) u_ram (
        .clk       (master.clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr[AW-1:0]),
        .i_wr_data (w_wr_pack),
        .i_rd_addr (r_rd_ptr[AW-1:0]),
        .o_rd_data (w_rd_pack)
    );

    always_ff @(posedge master.clk or negedge master.rstn) begin
        if (!master.rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Count of complete packets held; a last beat in and out together cancel.
    always_ff @(posedge master.clk or negedge master.rstn) begin
        if (!master.rstn) begin
            r_pkt_cnt <= '0;
        end else begin
            case ({w_wr_last, w_rd_last})
                2'b10:   r_pkt_cnt <= r_pkt_cnt + 1'b1;
                2'b01:   r_pkt_cnt <= r_pkt_cnt - 1'b1;
                default: r_pkt_cnt <= r_pkt_cnt;
            endcase
        end
    end

    // A packet larger than the buffer would deadlock store-and-forward, so it is
    // streamed out in cut-through until its own last beat leaves.
    always_ff @(posedge master.clk or negedge master.rstn) begin
        if (!master.rstn) begin
            r_force_ct <= 1'b0;
        end else if (MODE == MODE_CUT_THROUGH || w_rd_last) begin
            r_force_ct <= 1'b0;
        end else if (w_full && r_pkt_cnt == '0) begin
            r_force_ct <= 1'b1;
        end
    end

`ifdef STREAM_PKT_BUF_STATUS_EN
    assign level     = r_wr_ptr - r_rd_ptr;
    assign pkt_count = r_pkt_cnt;
`endif

endmodule

// File: tb/tb_stream_pkt_buf.sv
// Bench for stream_pkt_buf: DEPTH 4 cut-through, DEPTH 8 and DEPTH 4 store-and-forward
// instances, each checked cycle by cycle against a queue model of the buffer rules.
module tb_stream_pkt_buf;

    typedef struct packed {
        logic [3:0]  id;
        logic [3:0]  dest;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [3:0]  keep;
        logic        last;
        logic [1:0]  user;
    } beat_t;

    function automatic int depthOf(input int k);
        return (k == 1) ? 8 : 4;
    endfunction

    function automatic int modeOf(input int k);
        return (k == 0) ? 0 : 1;
    endfunction

    logic clock = 1'b0;
    logic rstn;
    always #5 clock = ~clock;

    logic  inValid  [3];
    beat_t inBeat   [3];
    logic  outReady [3];
    logic  inReady  [3];
    logic  outValid [3];
    beat_t outBeat  [3];
`ifdef STREAM_PKT_BUF_STATUS_EN
    logic [7:0] levelObs [3];
    logic [7:0] pktObs   [3];
`endif

    for (genvar g = 0; g < 3; g++) begin : gDut
        stream_channel upIf (.clk(clock), .rstn(rstn));
        stream_channel dnIf (.clk(clock), .rstn(rstn));

        assign upIf.t_valid = inValid[g];
        assign upIf.t_id    = inBeat[g].id;
        assign upIf.t_dest  = inBeat[g].dest;
        assign upIf.t_data  = inBeat[g].data;
        assign upIf.t_strb  = inBeat[g].strb;
        assign upIf.t_keep  = inBeat[g].keep;
        assign upIf.t_last  = inBeat[g].last;
        assign upIf.t_user  = inBeat[g].user;
        assign inReady[g]   = upIf.t_ready;
        assign dnIf.t_ready = outReady[g];
        assign outValid[g]  = dnIf.t_valid;
        assign outBeat[g]   = {dnIf.t_id, dnIf.t_dest, dnIf.t_data, dnIf.t_strb,
                               dnIf.t_keep, dnIf.t_last, dnIf.t_user};
`ifdef STREAM_PKT_BUF_STATUS_EN
        logic [$clog2(depthOf(g)):0] lvl;
        logic [$clog2(depthOf(g)):0] pc;
        assign levelObs[g] = 8'(lvl);
        assign pktObs[g]   = 8'(pc);
`endif

        stream_pkt_buf #(
            .DEPTH       (depthOf(g)),
            .PACKET_MODE (modeOf(g))
        ) dut (
            .master    (upIf),
            .slave     (dnIf)
`ifdef STREAM_PKT_BUF_STATUS_EN
            ,
            .level     (lvl),
            .pkt_count (pc)
`endif
        );
    end

    int    testsRun = 0;
    int    testsFailed = 0;
    int    act = 0;
    int    modelDepth = 4;
    int    modelMode = 0;
    beat_t modelQ[$];
    bit    modelForce = 1'b0;
    bit    wasWritten = 1'b0;
    int    acceptedCnt = 0;
    int    dutDelivered = 0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic beat_t randBeat(input bit last);
        beat_t b;
        b.id   = 4'($urandom);
        b.dest = 4'($urandom);
        b.data = $urandom;
        b.strb = 4'($urandom);
        b.keep = 4'($urandom);
        b.last = last;
        b.user = 2'($urandom);
        return b;
    endfunction

    // One cycle on the active instance: drive, compare against the model, advance the model.
    task automatic applyStimulus(input bit v, input beat_t b, input bit rdy);
        bit expReady, expValid, readLast, fullNoLast;
        int nLast;
        inValid[act]  = v;
        inBeat[act]   = b;
        outReady[act] = rdy;
        #1;
        nLast = 0;
        foreach (modelQ[i]) if (modelQ[i].last) nLast++;
        expReady = modelQ.size() < modelDepth;
        expValid = modelQ.size() > 0 && (modelMode == 0 || nLast > 0 || modelForce);
        checkOutput("in_ready", 64'(inReady[act]), 64'(expReady));
        checkOutput("out_valid", 64'(outValid[act]), 64'(expValid));
        if (expValid) checkOutput("payload", 64'(outBeat[act]), 64'(modelQ[0]));
`ifdef STREAM_PKT_BUF_STATUS_EN
        checkOutput("level", 64'(levelObs[act]), 64'(modelQ.size()));
        checkOutput("pkt_count", 64'(pktObs[act]), 64'(nLast));
`endif
        if (outValid[act] && rdy) dutDelivered++;
        readLast   = expValid && rdy && modelQ[0].last;
        fullNoLast = (modelQ.size() == modelDepth) && (nLast == 0);
        if (expValid && rdy) void'(modelQ.pop_front());
        wasWritten = v && expReady;
        if (wasWritten) begin
            modelQ.push_back(b);
            acceptedCnt++;
        end
        if (readLast) modelForce = 1'b0;
        else if (modelMode == 1 && fullNoLast) modelForce = 1'b1;
        @(negedge clock);
    endtask

    task automatic selectDut(input int k);
        inValid[act]  = 1'b0;
        outReady[act] = 1'b0;
        act        = k;
        modelDepth = depthOf(k);
        modelMode  = modeOf(k);
        modelQ.delete();
        modelForce = 1'b0;
    endtask

    // Pushes one closing last beat, then reads until the model is empty.
    task automatic drainAll();
        bit sent = 1'b0;
        for (int c = 0; c < 200 && (!sent || modelQ.size() > 0); c++) begin
            applyStimulus(!sent, randBeat(1'b1), 1'b1);
            if (wasWritten) sent = 1'b1;
        end
        #1;
        checkOutput("drained_valid", 64'(outValid[act]), 64'd0);
        checkOutput("drained_ready", 64'(inReady[act]), 64'd1);
        checkOutput("conserved", 64'(dutDelivered), 64'(acceptedCnt));
        @(negedge clock);
    endtask

    task automatic pulseReset();
        inValid[act]  = 1'b0;
        outReady[act] = 1'b0;
        #3 rstn = 1'b0;
        #4;
        checkOutput("rst_mid_valid", 64'(outValid[act]), 64'd0);
        checkOutput("rst_mid_ready", 64'(inReady[act]), 64'd1);
`ifdef STREAM_PKT_BUF_STATUS_EN
        checkOutput("rst_mid_level", 64'(levelObs[act]), 64'd0);
`endif
        #1 rstn = 1'b1;
        acceptedCnt -= modelQ.size();
        modelQ.delete();
        modelForce = 1'b0;
        @(negedge clock);
    endtask

    task automatic runRandom(input int k, input int nBeats);
        int    sent = 0;
        bit    pend = 1'b0;
        bit    rdy;
        beat_t b = randBeat(1'b0);
        selectDut(k);
        for (int c = 0; c < 20 * nBeats && sent < nBeats; c++) begin
            if (!pend) begin
                pend = ($urandom_range(0, 3) != 0);
                b    = randBeat($urandom_range(0, 4) == 0);
            end
            rdy = ($urandom_range(0, 2) != 0);
            applyStimulus(pend, b, rdy);
            if (wasWritten) begin
                sent++;
                pend = 1'b0;
            end
        end
        checkOutput("rand_sent", 64'(sent), 64'(nBeats));
        drainAll();
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        for (int k = 0; k < 3; k++) begin
            inValid[k]  = 1'b0;
            inBeat[k]   = '0;
            outReady[k] = 1'b0;
        end
        rstn = 1'b0;
        #7;
        for (int k = 0; k < 3; k++) begin
            checkOutput("reset_ready", 64'(inReady[k]), 64'd1);
            checkOutput("reset_valid", 64'(outValid[k]), 64'd0);
`ifdef STREAM_PKT_BUF_STATUS_EN
            checkOutput("reset_level", 64'(levelObs[k]), 64'd0);
`endif
        end
        #5 rstn = 1'b1;
        @(negedge clock);

        // Cut-through fill to full with the output stalled, then drain in order.
        selectDut(0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, randBeat(i == 3), 1'b0);
        #1;
        checkOutput("fill_ready_low", 64'(inReady[act]), 64'd0);
`ifdef STREAM_PKT_BUF_STATUS_EN
        checkOutput("fill_level", 64'(levelObs[act]), 64'd4);
`endif
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, randBeat(1'b0), 1'b1);
        drainAll();

        // Store-and-forward hold-back of a 3-beat packet.
        selectDut(1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, randBeat(i == 2), 1'b1);
        #1;
        checkOutput("hold_first_valid", 64'(outValid[act]), 64'd1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, randBeat(1'b0), 1'b1);
        drainAll();

        // Oversize 6-beat packet through a 4-deep store-and-forward buffer.
        selectDut(2);
        begin
            beat_t pkt[6];
            int sentN = 0;
            for (int i = 0; i < 6; i++) pkt[i] = randBeat(i == 5);
            base = dutDelivered;
            for (int c = 0; c < 60 && sentN < 6; c++) begin
                applyStimulus(1'b1, pkt[sentN], 1'b1);
                if (wasWritten) sentN++;
            end
            for (int c = 0; c < 60 && modelQ.size() > 0; c++) applyStimulus(1'b0, randBeat(1'b0), 1'b1);
            checkOutput("oversize_delivered", 64'(dutDelivered - base), 64'd6);
        end
        applyStimulus(1'b1, randBeat(1'b0), 1'b1);
        #1;
        checkOutput("next_pkt_held", 64'(outValid[act]), 64'd0);
        applyStimulus(1'b1, randBeat(1'b1), 1'b1);
        #1;
        checkOutput("next_pkt_release", 64'(outValid[act]), 64'd1);
        drainAll();

        // Last beat read and last beat written in the same cycle.
        selectDut(1);
        applyStimulus(1'b1, randBeat(1'b1), 1'b0);
        applyStimulus(1'b1, randBeat(1'b1), 1'b1);
        #1;
        checkOutput("simul_valid", 64'(outValid[act]), 64'd1);
`ifdef STREAM_PKT_BUF_STATUS_EN
        checkOutput("simul_pkt_count", 64'(pktObs[act]), 64'd1);
`endif
        drainAll();

        // Reset with a partial packet buffered, then a fresh packet.
        selectDut(1);
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, randBeat(1'b0), 1'b1);
        pulseReset();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, randBeat(i == 2), 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, randBeat(1'b0), 1'b1);
        drainAll();

        // Randomised traffic with random backpressure.
        runRandom(0, 1000);
        runRandom(1, 400);
        runRandom(2, 400);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
